// File: rtl/warp_issue_scheduler.sv
// -----------------------------------------------------------------------------
// warp_issue_scheduler
//
// Shares a single lane array among NUM_WARPS warp contexts. Each cycle in
// which the issue slot can be (re)loaded, one eligible warp is chosen by
// quantum-limited round-robin, its FIFO head is popped, and the instruction
// is captured in a registered issue slot tagged with the warp ID. The slot
// is handed to the lanes with a valid/ready handshake.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   warp_enable      per-warp scheduling enable
//   fifo_valid       per-warp "FIFO has a head instruction"
//   fifo_data        per-warp head instruction, warp w at [32w+31:32w]
//   fifo_pop         one-hot pop of the selected warp (combinational)
//   lane_execute     issue slot valid (registered)
//   lane_instruction issued instruction (registered)
//   lane_warp_id     warp owning the slot (registered)
//   lane_ready       lanes accept the slot this cycle
//   issue_count      instructions accepted by the lanes (wraps)
//   stall_count      cycles with a valid slot and no ready (wraps)
//   busy             slot valid or any warp eligible
// -----------------------------------------------------------------------------
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int QUANTUM   = 4,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_WARPS-1:0]   warp_enable,
  input  logic [NUM_WARPS-1:0]   fifo_valid,
  input  logic [NUM_WARPS*32-1:0] fifo_data,
  output logic [NUM_WARPS-1:0]   fifo_pop,
  output logic                   lane_execute,
  output logic [31:0]            lane_instruction,
  output logic [WID_W-1:0]       lane_warp_id,
  input  logic                   lane_ready,
  output logic [31:0]            issue_count,
  output logic [31:0]            stall_count,
  output logic                   busy
);

  localparam int CNT_W = $clog2(QUANTUM + 1);

  // Registered state
  logic             exec_q,  exec_d;
  logic [31:0]      instr_q, instr_d;
  logic [WID_W-1:0] wid_q,   wid_d;
  logic [31:0]      issue_q, issue_d;
  logic [31:0]      stall_q, stall_d;
  logic [WID_W-1:0] cur_q,   cur_d;
  logic [CNT_W-1:0] qcnt_q,  qcnt_d;

  // Selection logic
  logic [NUM_WARPS-1:0] eligible;
  logic [31:0]          head_data [NUM_WARPS];
  logic                 load_en;
  logic                 keep_cur;
  logic                 scan_found;
  logic [WID_W-1:0]     scan_sel;
  logic [WID_W-1:0]     sel;
  logic                 sel_valid;
  logic                 pop_en;
  logic                 quantum_expired;

  assign eligible = fifo_valid & warp_enable;
  assign load_en  = !exec_q | lane_ready;

  assign quantum_expired = (qcnt_q >= CNT_W'(QUANTUM));

  // A zero quantum count means no warp currently owns the slot (after reset),
  // so the scan starts fresh from cur_q+1 = warp 0 instead of sticking to the
  // reset value of cur_q.
  assign keep_cur = eligible[cur_q] && (qcnt_q != '0) && !quantum_expired;

  // Round-robin scan cur+1, cur+2, ... with cur itself checked last. When the
  // quantum has expired and nobody else is eligible this naturally falls back
  // to cur_q.
  always_comb begin : rr_scan
    int idx;
    scan_found = 1'b0;
    scan_sel   = cur_q;
    idx        = 0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      idx = (int'(cur_q) + k) % NUM_WARPS;
      if (!scan_found && eligible[WID_W'(idx)]) begin
        scan_found = 1'b1;
        scan_sel   = WID_W'(idx);
      end
    end
  end

  assign sel       = keep_cur ? cur_q : scan_sel;
  assign sel_valid = keep_cur | scan_found;
  assign pop_en    = rst_n & load_en & sel_valid;

  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      assign head_data[gi] = fifo_data[32*gi +: 32];
      assign fifo_pop[gi]  = pop_en & (sel == WID_W'(gi));
    end
  endgenerate

  // Next-state logic
  always_comb begin
    exec_d  = exec_q;
    instr_d = instr_q;
    wid_d   = wid_q;
    issue_d = issue_q;
    stall_d = stall_q;
    cur_d   = cur_q;
    qcnt_d  = qcnt_q;

    if (exec_q && lane_ready)  issue_d = issue_q + 32'd1;
    if (exec_q && !lane_ready) stall_d = stall_q + 32'd1;

    if (load_en) begin
      if (sel_valid) begin
        exec_d  = 1'b1;
        instr_d = head_data[sel];
        wid_d   = sel;
        cur_d   = sel;
        qcnt_d  = ((sel != cur_q) || quantum_expired) ? CNT_W'(1) : qcnt_q + CNT_W'(1);
      end else begin
        // Bubble: slot empties, payload and round-robin state hold.
        exec_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q  <= 1'b0;
      instr_q <= '0;
      wid_q   <= '0;
      issue_q <= '0;
      stall_q <= '0;
      cur_q   <= WID_W'(NUM_WARPS - 1);
      qcnt_q  <= '0;
    end else begin
      exec_q  <= exec_d;
      instr_q <= instr_d;
      wid_q   <= wid_d;
      issue_q <= issue_d;
      stall_q <= stall_d;
      cur_q   <= cur_d;
      qcnt_q  <= qcnt_d;
    end
  end

  assign lane_execute     = exec_q;
  assign lane_instruction = instr_q;
  assign lane_warp_id     = wid_q;
  assign issue_count      = issue_q;
  assign stall_count      = stall_q;
  assign busy             = exec_q | (|eligible);

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_warp_issue_scheduler
//
// Randomised and directed stimulus for warp_issue_scheduler. A reference
// model predicts, per cycle, which warp is selected and pushes the expected
// (warp, instruction) into a scoreboard; an independent monitor pops and
// compares whenever the lanes accept the slot.
// -----------------------------------------------------------------------------
module tb_warp_issue_scheduler;

  localparam int NW = 4;
  localparam int Q  = 4;
  localparam int WW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW-1:0]     warp_enable = '0;
  logic [NW-1:0]     fifo_valid = '0;
  logic [NW*32-1:0]  fifo_data = '0;
  logic [NW-1:0]     fifo_pop;
  logic              lane_execute;
  logic [31:0]       lane_instruction;
  logic [WW-1:0]     lane_warp_id;
  logic              lane_ready = 1'b0;
  logic [31:0]       issue_count;
  logic [31:0]       stall_count;
  logic              busy;

  warp_issue_scheduler #(.NUM_WARPS(NW), .QUANTUM(Q), .WID_W(WW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .warp_enable      (warp_enable),
    .fifo_valid       (fifo_valid),
    .fifo_data        (fifo_data),
    .fifo_pop         (fifo_pop),
    .lane_execute     (lane_execute),
    .lane_instruction (lane_instruction),
    .lane_warp_id     (lane_warp_id),
    .lane_ready       (lane_ready),
    .issue_count      (issue_count),
    .stall_count      (stall_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-side warp FIFOs and stimulus controls
  logic [31:0] fq [NW][$];
  logic [NW-1:0] vmask = '1;
  bit rand_mode = 1'b0;

  // Scoreboard entries: {warp id, instruction}
  logic [WW+31:0] sb [$];
  int id_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    for (int w = 0; w < NW; w++) begin
      fifo_valid[w] = (fq[w].size() > 0) && vmask[w];
      fifo_data[32*w +: 32] = (fq[w].size() > 0) ? fq[w][0] : 32'h0;
    end
  endtask

  // One clock: observe pops before the edge, consume them after it, then
  // refresh inputs (#1 after the edge).
  task automatic step();
    logic [NW-1:0] p;
    int r;
    @(negedge clk);
    p = fifo_pop;
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int w = 0; w < NW; w++)
        if (p[w] && fq[w].size() > 0) void'(fq[w].pop_front());
    end
    if (rand_mode) begin
      lane_ready = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < NW; w++) begin
        vmask[w] = ($urandom_range(0, 7) != 0);
        if (fq[w].size() < 4 && $urandom_range(0, 1) == 1) fq[w].push_back($urandom);
      end
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, NW - 1);
        warp_enable[r] = ~warp_enable[r];
      end
    end
    drive_fifo();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int w = 0; w < NW; w++) fq[w].delete();
    warp_enable = '0;
    vmask = '1;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    id_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic expect_ids(input string name, input int exp[$]);
    chk({name, "_len"}, 64'(id_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < id_log.size(); i++)
      chk(name, 64'(id_log[i]), 64'(exp[i]));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: quantum-limited round-robin from the scheduling rules.
  // ---------------------------------------------------------------------------
  initial begin : ref_model
    int m_cur, m_q, sel, c;
    bit m_slot;
    logic [NW-1:0] elig, exp_pop;
    m_cur = NW - 1; m_q = 0; m_slot = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cur = NW - 1; m_q = 0; m_slot = 0;
        chk("pop_in_reset", 64'(fifo_pop), 64'(0));
        chk("exec_in_reset", 64'(lane_execute), 64'(0));
      end else begin
        elig = fifo_valid & warp_enable;
        chk("lane_execute", 64'(lane_execute), 64'(m_slot));
        chk("busy", 64'(busy), 64'(m_slot || (elig != 0)));
        exp_pop = '0;
        if (!m_slot || lane_ready) begin
          sel = -1;
          if (m_q > 0 && m_q < Q && elig[m_cur]) sel = m_cur;
          else begin
            for (int k = 1; k <= NW; k++) begin
              c = (m_cur + k) % NW;
              if (sel < 0 && elig[c]) sel = c;
            end
          end
          if (sel >= 0) begin
            exp_pop[sel] = 1'b1;
            sb.push_back({WW'(sel), fifo_data[32*sel +: 32]});
            m_q = (sel == m_cur && m_q < Q) ? m_q + 1 : 1;
            m_cur = sel;
            m_slot = 1;
          end else begin
            m_slot = 0;
          end
        end
        chk("fifo_pop", 64'(fifo_pop), 64'(exp_pop));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares accepted slots against the scoreboard, tracks counters.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    int m_issue, m_stall;
    logic [WW+31:0] e;
    m_issue = 0; m_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        m_issue = 0; m_stall = 0;
        chk("issue_count_rst", 64'(issue_count), 64'(0));
        chk("stall_count_rst", 64'(stall_count), 64'(0));
      end else begin
        chk("issue_count", 64'(issue_count), 64'(m_issue));
        chk("stall_count", 64'(stall_count), 64'(m_stall));
        if (lane_execute && lane_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_issue", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            $display("issue wid=%0d instr=%08h", lane_warp_id, lane_instruction);
            chk("lane_instruction", 64'(lane_instruction), 64'(e[31:0]));
            chk("lane_warp_id", 64'(lane_warp_id), 64'(e[WW+31:32]));
          end
          id_log.push_back(int'(lane_warp_id));
          m_issue++;
        end else if (lane_execute) begin
          m_stall++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int exp_ids [$];
    bit seen;

    // Single warp, 6 instructions back to back
    do_reset();
    chk("reset_exec", 64'(lane_execute), 64'(0));
    chk("reset_instr", 64'(lane_instruction), 64'(0));
    chk("reset_wid", 64'(lane_warp_id), 64'(0));
    lane_ready = 1'b1;
    warp_enable = 4'b0001;
    for (int i = 0; i < 6; i++) fq[0].push_back(32'h100 + 32'(i));
    drive_fifo();
    repeat (7) step();
    chk("single_issue_cnt", 64'(issue_count), 64'(6));
    chk("single_stall_cnt", 64'(stall_count), 64'(0));
    exp_ids = {0, 0, 0, 0, 0, 0};
    expect_ids("single_ids", exp_ids);

    // Quantum round-robin between warps 0 and 1
    do_reset();
    lane_ready = 1'b1;
    warp_enable = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      fq[0].push_back(32'h0A00 + 32'(i));
      fq[1].push_back(32'h1A00 + 32'(i));
    end
    drive_fifo();
    repeat (20) step();
    exp_ids = {0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    expect_ids("rr_ids", exp_ids);

    // Quantum expiry with no competitor
    do_reset();
    lane_ready = 1'b1;
    warp_enable = 4'b0100;
    for (int i = 0; i < 10; i++) fq[2].push_back(32'h2B00 + 32'(i));
    drive_fifo();
    repeat (11) step();
    chk("solo_no_bubble_cnt", 64'(issue_count), 64'(10));
    exp_ids = {2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    expect_ids("solo_ids", exp_ids);

    // Backpressure
    do_reset();
    lane_ready = 1'b0;
    warp_enable = 4'b0001;
    fq[0].push_back(32'hDEADBEEF);
    fq[0].push_back(32'h11111111);
    drive_fifo();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = lane_execute;
    end
    chk("bp_slot_loaded", 64'(seen), 64'(1));
    for (int i = 0; i < 3; i++) begin
      chk("bp_slot_stable", 64'(lane_instruction), 64'(32'hDEADBEEF));
      chk("bp_no_pop", 64'(fifo_pop), 64'(0));
      step();
    end
    chk("bp_stall_cnt", 64'(stall_count), 64'(3));
    lane_ready = 1'b1;
    step();
    chk("bp_next_instr", 64'(lane_instruction), 64'(32'h11111111));
    chk("bp_next_exec", 64'(lane_execute), 64'(1));
    chk("bp_issue_cnt", 64'(issue_count), 64'(1));

    // Disable a warp while its instruction sits in the slot
    do_reset();
    lane_ready = 1'b1;
    warp_enable = 4'b1011;
    fq[0].push_back(32'hA0); fq[0].push_back(32'hA1);
    for (int i = 0; i < 4; i++) fq[1].push_back(32'hB0 + 32'(i));
    fq[3].push_back(32'hD0); fq[3].push_back(32'hD1);
    drive_fifo();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (lane_execute && lane_warp_id == 1) begin
        seen = 1;
        warp_enable[1] = 1'b0;
        drive_fifo();
      end
    end
    chk("skip_w1_in_slot", 64'(seen), 64'(1));
    repeat (6) step();
    exp_ids = {0, 0, 1, 3, 3};
    expect_ids("skip_ids", exp_ids);

    // Randomised traffic with a reset in the middle
    do_reset();
    warp_enable = '1;
    rand_mode = 1'b1;
    repeat (600) step();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = lane_execute;
    end
    chk("rand_slot_before_reset", 64'(seen), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_exec", 64'(lane_execute), 64'(0));
    chk("async_rst_issue", 64'(issue_count), 64'(0));
    chk("async_rst_stall", 64'(stall_count), 64'(0));
    chk("async_rst_pop", 64'(fifo_pop), 64'(0));
    rand_mode = 1'b0;
    lane_ready = 1'b1;
    vmask = '1;
    warp_enable = '1;
    for (int w = 0; w < NW; w++) begin
      fq[w].push_back($urandom);
      fq[w].push_back($urandom);
    end
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    id_log.delete();
    rst_n = 1'b1;
    repeat (4) step();
    chk("first_id_after_reset", 64'((id_log.size() > 0) ? id_log[0] : 99), 64'(0));
    rand_mode = 1'b1;
    repeat (600) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
Shares one lane array among NUM_WARPS warp contexts. Each warp has its own instruction FIFO. Each cycle the scheduler picks one eligible warp by quantum-limited round-robin, pops one instruction from that warp's FIFO, and holds it in a registered issue slot. The slot is presented to the lane array with a valid/ready handshake, tagged with the issuing warp ID.

Parameters:
NUM_WARPS, 4, number of warp contexts (≥2).
QUANTUM, 4, max consecutive issues by one warp while another warp is eligible (≥1).
WID_W, $clog2(NUM_WARPS), width of warp ID.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
warp_enable  in  NUM_WARPS  per-warp scheduling enable
fifo_valid  in  NUM_WARPS  per-warp FIFO has a head instruction
fifo_data  in  NUM_WARPS*32  per-warp head instruction; warp w at bits [32w+31:32w]
fifo_pop  out  NUM_WARPS  one-hot pop, combinational, ≤1 bit set
lane_execute  out  1  issue slot valid (registered)
lane_instruction  out  32  issued instruction (registered)
lane_warp_id  out  WID_W  warp owning the slot (registered)
lane_ready  in  1  lane array accepts the slot this cycle
issue_count  out  32  total instructions accepted by lanes
stall_count  out  32  cycles with lane_execute=1 and lane_ready=0
busy  out  1  lane_execute | (|(fifo_valid & warp_enable))

Behaviour:
- Reset values: lane_execute=0, lane_instruction=0, lane_warp_id=0, issue_count=0, stall_count=0, cur_warp=NUM_WARPS-1, quantum_cnt=0. fifo_pop=0 while in reset.
- Eligibility: eligible[w] = fifo_valid[w] & warp_enable[w].
- Slot load: load_en = !lane_execute | lane_ready. This gives full throughput of one instruction per cycle under continuous lane_ready.
- Selection, evaluated only when load_en:
  - Keep the current warp if eligible[cur_warp] & (quantum_cnt < QUANTUM).
  - Also keep it if quantum_cnt ≥ QUANTUM and no other warp is eligible.
  - Otherwise pick the first eligible warp scanning cur_warp+1, cur_warp+2, … with wrap modulo NUM_WARPS; cur_warp itself is last.
- On a selection (any eligible warp):
  - fifo_pop[sel]=1 in the same cycle.
  - Next edge: lane_execute=1, lane_instruction=fifo_data[sel], lane_warp_id=sel, cur_warp=sel.
  - quantum_cnt = 1 if sel≠cur_warp or the quantum had expired; otherwise quantum_cnt+1.
- No eligible warp while load_en: fifo_pop=0. Next edge: lane_execute=0. lane_instruction and lane_warp_id hold their values. cur_warp and quantum_cnt are unchanged.
- Backpressure: while lane_execute & !lane_ready:
  - Slot contents are frozen and no pop occurs.
  - stall_count increments by 1.
- Accept: lane_execute & lane_ready increments issue_count by 1. Accept and refill happen in the same cycle.
- Counters wrap modulo 2^32.
- Latency: 1 cycle from pop to lane_execute.
- warp_enable deasserted for the warp already in the slot: the slot is NOT cancelled; it issues normally. That warp is excluded from subsequent selections.
- fifo_valid dropping mid-quantum forces a switch to the next eligible warp, even though the quantum is not expired.
- Asynchronous reset mid-operation discards the slot contents (lane_execute→0 immediately). The scheduler restarts the scan at warp 0.
- fifo_pop is never asserted for a warp with fifo_valid=0 or warp_enable=0.

Test Plan:
- Single warp: warp 0 enabled with 6 instructions 0x100..0x105, lane_ready=1 → lane_execute high for 6 consecutive cycles with data 0x100..0x105 and lane_warp_id=0; issue_count=6, stall_count=0.
- Quantum round-robin: warps 0 and 1 each hold 8 instructions, QUANTUM=4, lane_ready=1 → issue warp-ID order 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1.
- Quantum expiry, no competitor: only warp 2 has 10 instructions → 10 back-to-back issues, all with ID 2, no bubbles.
- Backpressure: lane_ready held low for 3 cycles while the slot holds 0xDEADBEEF → slot stable, fifo_pop=0, stall_count=3; then lane_ready=1 → accept, next instruction loaded on the following edge.
- Disable/skip: warps 0, 1 and 3 eligible, then warp_enable[1]=0 → order skips 1 (0 then 3). The instruction from warp 1 already in the slot still issues.
- Reset mid-stream: assert rst_n=0 while lane_execute=1 → lane_execute=0 asynchronously and counters=0. After release with all warps eligible, the first issued ID is 0.
